majority_sampler: RTL

- Upstream conditioning stage for the 3-input majority voter.
- Synchronises a noisy single-bit input and samples it on a programmable prescaled tick.
- Keeps the last three samples as a 3-bit window for the voter, and also produces its own registered filtered output with edge pulses.
- Sits between an asynchronous pin/sensor and the voting/decision logic.

---
 rtl/majority_pkg.sv | 8 +
 rtl/majority_sampler_if.sv | 18 +
 rtl/majority_sampler_prescaler.sv | 29 ++
 rtl/majority_sampler.sv | 82 ++++++++
 4 files changed

// File: rtl/majority_pkg.sv
// Shared definitions for the majority sampler and the downstream 3-input voter.
package majority_pkg;
  localparam int WIN_W = 3;

  function automatic logic maj3(input logic [WIN_W-1:0] a);
    return (a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2]);
  endfunction
endpackage

// File: rtl/majority_sampler_if.sv
// Control inputs and sampled/filtered outputs of the majority sampler.
interface majority_sampler_if;
  import majority_pkg::*;
  logic             din;
  logic             en;
  logic             clr;
  logic [WIN_W-1:0] win;
  logic             win_valid;
  logic             tick;
  logic             filt;
  logic             rise;
  logic             fall;

  modport master (output din, en, clr,
                  input  win, win_valid, tick, filt, rise, fall);
  modport slave  (input  din, en, clr,
                  output win, win_valid, tick, filt, rise, fall);
endinterface

// File: rtl/majority_sampler_prescaler.sv
// Free-running 0..DIV-1 counter gated by en; tick_i is combinational on the last count.
module sample_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_i
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_i = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)         cnt_d = '0;
    else if (tick_i) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/majority_sampler.sv
// Synchronise din, sample it on a prescaled tick into a 3-deep window and
// produce a registered 2-of-3 filtered output with edge pulses.
module majority_sampler
  import majority_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  majority_sampler_if.slave  bus
);
  logic             s1_q, s2_q;
  logic             tick_i;
  logic [WIN_W-1:0] win_q;
  logic [1:0]       fill_q, fill_d;
  logic             vld_q, tick_q, filt_q, rise_q, fall_q;
  logic             m;

  sample_prescaler #(.DIV(DIV)) u_pre (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.en),
    .clr    (bus.clr),
    .tick_i (tick_i)
  );

  // Synchroniser is deliberately outside clr so a flush never loses the pin state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.din;
      s2_q <= s1_q;
    end
  end

  assign fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
  // Vote on the window as it is being loaded, so filt tracks win in the same cycle.
  assign m      = maj3({win_q[1:0], s2_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
      vld_q  <= 1'b0;
      tick_q <= 1'b0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (bus.clr) begin
      win_q  <= '0;
      fill_q <= '0;
      vld_q  <= 1'b0;
      tick_q <= 1'b0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      tick_q <= tick_i;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (tick_i) begin
        win_q  <= {win_q[1:0], s2_q};
        fill_q <= fill_d;
        vld_q  <= (fill_d == 2'd3);
        if (fill_d == 2'd3) begin
          filt_q <= m;
          rise_q <= m & ~filt_q;
          fall_q <= ~m & filt_q;
        end
      end
    end
  end

  assign bus.win       = win_q;
  assign bus.win_valid = vld_q;
  assign bus.tick      = tick_q;
  assign bus.filt      = filt_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
endmodule
